// File: rtl/fifo_pop_stream.sv
// Read-side client of a registered-output async FIFO: pops words into a
// two-entry buffer and replays them as a valid/ready stream of RATIO beats per word.
module fifo_pop_stream #(
   parameter int DW    = 8,
   parameter int RATIO = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                fifo_ren,
   input  logic [DW-1:0]       fifo_rdata,
   input  logic                fifo_rempty,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [DW/RATIO-1:0] m_data,
   output logic                m_last
);

   localparam int OW = DW / RATIO;
   localparam int BW = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

   logic [1:0]    occ_q, occ_d;
   logic          inflight_q, inflight_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [DW-1:0] head_q, head_d;
   logic [DW-1:0] tail_q, tail_d;
   logic          beat_fire;
   logic          word_done;
   logic [1:0]    pending;

   always_comb begin
      m_valid = (occ_q != 2'd0);
      m_last  = m_valid && (beat_q == LAST_BEAT);
      m_data  = head_q[OW-1:0];
      for (int i = 1; i < RATIO; i++) begin
         if (beat_q == BW'(i)) begin
            m_data = head_q[i*OW +: OW];
         end
      end

      beat_fire = m_valid && m_ready;
      word_done = beat_fire && m_last;

      // Words held or on their way once this cycle's drain is accounted for;
      // a word_done always implies occ_q >= 1, so this never underflows.
      pending  = occ_q + {1'b0, inflight_q} - {1'b0, word_done};
      fifo_ren = rst_n && !fifo_rempty && (pending < 2'd2);

      inflight_d = fifo_ren;
      occ_d      = pending;

      beat_d = beat_q;
      if (beat_fire) begin
         beat_d = word_done ? '0 : beat_q + BW'(1);
      end

      head_d = head_q;
      tail_d = tail_q;
      if (word_done) begin
         head_d = tail_q;
      end
      // Returning read data lands in head when head is free (or freeing now
      // with nothing behind it), otherwise behind the current head.
      if (inflight_q) begin
         if ((occ_q == 2'd0) || ((occ_q == 2'd1) && word_done)) begin
            head_d = fifo_rdata;
         end else begin
            tail_d = fifo_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         beat_q     <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         beat_q     <= beat_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   a_no_pop_when_empty : assert property (
      @(posedge clk) disable iff (!rst_n) !(fifo_ren && fifo_rempty));

   a_no_overflow : assert property (
      @(posedge clk) disable iff (!rst_n) ({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2);

   a_stable_under_stall : assert property (
      @(posedge clk) disable iff (!rst_n) (m_valid && !m_ready) |=> $stable(m_data));

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Scoreboard bench for fifo_pop_stream: an unsplit 8-bit instance and a
// 32-bit instance split into four 8-bit beats, both fed from queue-based FIFO models.
module tb_fifo_pop_stream;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        a_ren, a_rempty = 1'b1, a_valid, a_ready, a_last;
   logic [7:0]  a_rdata, a_data;
   logic        b_ren, b_rempty = 1'b1, b_valid, b_ready, b_last;
   logic [31:0] b_rdata;
   logic [7:0]  b_data;

   int total_checks  = 0;
   int passed_checks = 0;

   // FIFO contents and expected beats ({last, data}) per instance
   logic [7:0]  fa[$];
   logic [31:0] fb[$];
   logic [8:0]  expa[$];
   logic [8:0]  expb[$];
   logic [8:0]  exp_beat;

   int cyc = 0, base = 0, mon_k;
   int ren_cnt, first_ren, valid_cnt, first_valid, streak, max_streak, prev_valid_k;

   always #5 clk = ~clk;

   fifo_pop_stream #(.DW(8), .RATIO(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .fifo_ren(a_ren), .fifo_rdata(a_rdata),
      .fifo_rempty(a_rempty), .m_valid(a_valid), .m_ready(a_ready),
      .m_data(a_data), .m_last(a_last));

   fifo_pop_stream #(.DW(32), .RATIO(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .fifo_ren(b_ren), .fifo_rdata(b_rdata),
      .fifo_rempty(b_rempty), .m_valid(b_valid), .m_ready(b_ready),
      .m_data(b_data), .m_last(b_last));

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_checks++;
      if (actual === expected) begin
         passed_checks++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc - base);
      end
   endtask

   // Queue a word into a FIFO model and record the beats it must produce
   task automatic applyStimulus(input int sel, input logic [31:0] word);
      if (sel == 0) begin
         fa.push_back(word[7:0]);
         expa.push_back({1'b1, word[7:0]});
      end else begin
         fb.push_back(word);
         for (int j = 0; j < 4; j++) begin
            expb.push_back({(j == 3), word[j*8 +: 8]});
         end
      end
   endtask

   task automatic clearStats();
      base         = cyc;
      ren_cnt      = 0;
      first_ren    = -1;
      valid_cnt    = 0;
      first_valid  = -1;
      streak       = 0;
      max_streak   = 0;
      prev_valid_k = -10;
   endtask

   always @(posedge clk) cyc++;

   // FIFO models: registered read data the cycle after a pop, empty flag refreshed mid-cycle
   always @(posedge clk) begin
      if (a_ren && fa.size() > 0) a_rdata <= fa.pop_front();
      if (b_ren && fb.size() > 0) b_rdata <= fb.pop_front();
   end

   always @(posedge clk) begin
      #3;
      a_rempty = (fa.size() == 0);
      b_rempty = (fb.size() == 0);
   end

   // Monitor: timing statistics for instance A and in-order beat checking for both
   always @(negedge clk) begin
      if (rst_n) begin
         mon_k = cyc - base;
         if (a_ren) begin
            ren_cnt++;
            if (first_ren < 0) first_ren = mon_k;
         end
         if (a_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = mon_k;
            streak = (prev_valid_k == mon_k - 1) ? streak + 1 : 1;
            prev_valid_k = mon_k;
            if (streak > max_streak) max_streak = streak;
         end
         if (a_valid && a_ready) begin
            if (expa.size() == 0) begin
               total_checks++;
               $display("[TB] FAIL a_beat: got 0x%0h, expected no beat", {a_last, a_data});
            end else begin
               exp_beat = expa.pop_front();
               checkOutput("a_beat", {23'd0, a_last, a_data}, {23'd0, exp_beat});
            end
         end
         if (b_valid && b_ready) begin
            if (expb.size() == 0) begin
               total_checks++;
               $display("[TB] FAIL b_beat: got 0x%0h, expected no beat", {b_last, b_data});
            end else begin
               exp_beat = expb.pop_front();
               checkOutput("b_beat", {23'd0, b_last, b_data}, {23'd0, exp_beat});
            end
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      a_ready = 1'b0;
      b_ready = 1'b0;
      a_rdata = '0;
      b_rdata = '0;
      clearStats();

      // Reset held with a non-empty FIFO: nothing may move
      applyStimulus(0, 32'hA5);
      a_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checkOutput("reset_ren", a_ren, 0);
         checkOutput("reset_valid", a_valid, 0);
         checkOutput("reset_data", a_data, 0);
         checkOutput("reset_last", a_last, 0);
      end

      // Single word latency
      @(posedge clk); #1;
      rst_n = 1'b1;
      clearStats();
      repeat (6) @(posedge clk);
      #1;
      checkOutput("single_first_ren", first_ren, 0);
      checkOutput("single_ren_cnt", ren_cnt, 1);
      checkOutput("single_first_valid", first_valid, 2);
      checkOutput("single_valid_cnt", valid_cnt, 1);

      // Streaming 16 words back to back
      clearStats();
      for (int i = 0; i < 16; i++) applyStimulus(0, i);
      repeat (22) @(posedge clk);
      #1;
      checkOutput("stream_first_valid", first_valid, 2);
      checkOutput("stream_valid_cnt", valid_cnt, 16);
      checkOutput("stream_no_bubble", max_streak, 16);
      checkOutput("stream_drained", expa.size(), 0);

      // Backpressure: two pops fill the buffer, head held
      a_ready = 1'b0;
      clearStats();
      for (int i = 0; i < 8; i++) applyStimulus(0, 32'h30 + i);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("stall_ren_cnt", ren_cnt, 2);
      checkOutput("stall_valid", a_valid, 1);
      checkOutput("stall_data", a_data, 32'h30);
      a_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("stall_drained", expa.size(), 0);
      checkOutput("stall_total_ren", ren_cnt, 8);

      // Split instance with alternating ready
      applyStimulus(1, 32'h44332211);
      applyStimulus(1, 32'h88776655);
      b_ready = 1'b1;
      repeat (24) begin
         @(posedge clk); #1;
         b_ready = !b_ready;
      end
      checkOutput("split_drained", expb.size(), 0);

      // Random traffic on both instances
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 2) == 0 && fa.size() < 6) applyStimulus(0, $urandom);
         if ($urandom_range(0, 3) == 0 && fb.size() < 3) applyStimulus(1, $urandom);
         a_ready = 1'($urandom_range(0, 1));
         b_ready = ($urandom_range(0, 3) != 0);
      end
      a_ready = 1'b1;
      b_ready = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      checkOutput("rand_a_drained", expa.size(), 0);
      checkOutput("rand_b_drained", expb.size(), 0);

      // Reset with a word buffered and another in flight
      a_ready = 1'b0;
      b_ready = 1'b0;
      clearStats();
      for (int i = 0; i < 4; i++) applyStimulus(0, 32'hC0 + i);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      fa.delete();
      fb.delete();
      expa.delete();
      expb.delete();
      @(negedge clk);
      checkOutput("midrst_ren", a_ren, 0);
      checkOutput("midrst_valid", a_valid, 0);
      checkOutput("midrst_data", a_data, 0);
      checkOutput("midrst_last", a_last, 0);
      checkOutput("midrst_b_valid", b_valid, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      a_ready = 1'b1;
      clearStats();
      repeat (6) @(posedge clk);
      #1;
      checkOutput("midrst_no_capture", valid_cnt, 0);
      checkOutput("midrst_no_ren", ren_cnt, 0);

      applyStimulus(0, 32'h5A);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("post_rst_drained", expa.size(), 0);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
